// File: rtl/data_mem_io_if.sv
// CPU data-memory bus: master is the CPU core, slave is data_mem_io.
// No backpressure: write strobe is single-cycle, and read data follows the read address by one cycle.
interface data_mem_io_if;
  logic        write_m;
  logic [14:0] write_data_addr;
  logic [15:0] out_m;
  logic [14:0] read_data_addr;
  logic [15:0] in_m;

  modport master (output write_m, write_data_addr, out_m, read_data_addr, input in_m);
  modport slave  (input write_m, write_data_addr, out_m, read_data_addr, output in_m);
endinterface

// File: rtl/data_mem_io.sv
// Data-memory responder: sync RAM + 8-word I/O page (SW, LED, timer); in_m is 1 cycle, read-first, never stalls.
// Timer/snapshot/TIMER_CTRL exist only when DATA_MEM_TIMER_EN is defined; otherwise offsets +2..+4 read as reserved.
module data_mem_io #(
  parameter int          RAM_AW         = 14,
  parameter logic [14:0] IO_BASE        = 15'h6000,
  parameter int          TIMER_PRESCALE = 1
) (
  input  logic         clk,
  input  logic         resetN,
  data_mem_io_if.slave bus,
  input  logic [3:0]   SW,
  output logic [15:0]  led
);
  localparam logic [31:0] RAM_WORDS = 32'd1 << RAM_AW;
  localparam logic [2:0]  OFF_SW    = 3'd0;
  localparam logic [2:0]  OFF_LED   = 3'd1;
  localparam logic [2:0]  OFF_TLO   = 3'd2;
  localparam logic [2:0]  OFF_THI   = 3'd3;
  localparam logic [2:0]  OFF_CTRL  = 3'd4;

  if (TIMER_PRESCALE < 1 || TIMER_PRESCALE > 65535) begin : g_bad_prescale
    $error("data_mem_io: TIMER_PRESCALE must be 1..65535");
  end

  // Address decode; RAM takes priority should the I/O page ever overlap it.
  logic       wr_ram, wr_io, rd_ram, rd_io, io_we;
  logic [2:0] wr_off, rd_off;

  assign wr_ram = {17'b0, bus.write_data_addr} < RAM_WORDS;
  assign wr_io  = !wr_ram && (bus.write_data_addr[14:3] == IO_BASE[14:3]);
  assign wr_off = bus.write_data_addr[2:0];
  assign rd_ram = {17'b0, bus.read_data_addr} < RAM_WORDS;
  assign rd_io  = !rd_ram && (bus.read_data_addr[14:3] == IO_BASE[14:3]);
  assign rd_off = bus.read_data_addr[2:0];
  assign io_we  = bus.write_m && wr_io;

  // RAM has no reset so it maps onto block RAM; the NBA write keeps the read old-value.
  logic [15:0] mem [0:(1<<RAM_AW)-1];
  logic [15:0] ram_rd_q;

  always_ff @(posedge clk) begin
    if (bus.write_m && wr_ram) begin
      mem[bus.write_data_addr[RAM_AW-1:0]] <= bus.out_m;
    end
    ram_rd_q <= mem[bus.read_data_addr[RAM_AW-1:0]];
  end

  logic [3:0]  sw_meta_q, sw_sync_q;
  logic [15:0] led_q, led_d;
  logic [15:0] io_rd_q, io_rd_d;
  logic        rd_ram_q, rd_ram_d;

`ifdef DATA_MEM_TIMER_EN
  localparam logic [15:0] PRESC_MAX = 16'(TIMER_PRESCALE - 1);

  logic        en_q, en_d;
  logic [15:0] presc_q, presc_d;
  logic [31:0] count_q, count_d;
  logic [15:0] snap_q, snap_d;
  logic        ctrl_we;

  assign ctrl_we = io_we && (wr_off == OFF_CTRL);

  always_comb begin
    en_d    = en_q;
    presc_d = presc_q;
    count_d = count_q;
    snap_d  = snap_q;
    if (rd_io && rd_off == OFF_TLO) begin
      snap_d = count_q[31:16];
    end
    if (en_q) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        count_d = count_q + 32'd1;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
    // Clear overrides any increment in the same cycle; bit1 is never stored.
    if (ctrl_we) begin
      en_d = bus.out_m[0];
      if (bus.out_m[1]) begin
        presc_d = '0;
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      en_q    <= 1'b0;
      presc_q <= '0;
      count_q <= '0;
      snap_q  <= '0;
    end else begin
      en_q    <= en_d;
      presc_q <= presc_d;
      count_q <= count_d;
      snap_q  <= snap_d;
    end
  end
`endif

  always_comb begin
    led_d = led_q;
    if (io_we && wr_off == OFF_LED) begin
      led_d = bus.out_m;
    end
  end

  always_comb begin
    rd_ram_d = rd_ram;
    io_rd_d  = '0;
    if (rd_io) begin
      case (rd_off)
        OFF_SW:   io_rd_d = {12'b0, sw_sync_q};
        OFF_LED:  io_rd_d = led_q;
`ifdef DATA_MEM_TIMER_EN
        OFF_TLO:  io_rd_d = count_q[15:0];
        OFF_THI:  io_rd_d = snap_q;
        OFF_CTRL: io_rd_d = {15'b0, en_q};
`endif
        default:  io_rd_d = '0;
      endcase
    end
  end

  // io_rd_q is zero unless the previous read hit the I/O page, which also covers unmapped reads.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      led_q     <= '0;
      io_rd_q   <= '0;
      rd_ram_q  <= 1'b0;
    end else begin
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
      led_q     <= led_d;
      io_rd_q   <= io_rd_d;
      rd_ram_q  <= rd_ram_d;
    end
  end

  assign bus.in_m = rd_ram_q ? ram_rd_q : io_rd_q;
  assign led      = led_q;
endmodule

// File: tb/tb_data_mem_io.sv
// Scoreboarded bench for data_mem_io: driver pushes model-predicted in_m/led per cycle, monitor pops and compares.
`timescale 1ns/1ps
module tb_data_mem_io;
  localparam int P = 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic        chk;
    logic        dir;
    logic [14:0] ra;
    logic [15:0] in_exp;
    logic [15:0] led_exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [3:0]  SW = 4'h0;
  logic [15:0] led;
  logic [31:0] cyc_cnt = 32'd0;

  data_mem_io_if bus();

  data_mem_io #(.RAM_AW(14), .IO_BASE(15'h6000), .TIMER_PRESCALE(P)) dut (
    .clk(clk), .resetN(resetN), .bus(bus), .SW(SW), .led(led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 32'd1;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t mon_e;

  // Reference state: RAM contents written so far, LED, switch history, timer as elapsed enabled cycles.
  logic [15:0]     ram_m [int];
  logic [15:0]     led_m = 16'h0;
  logic [3:0]      sw_h0 = 4'h0, sw_h1 = 4'h0, sw_drv = 4'h0;
  bit              en_m = 1'b0;
  longint unsigned ticks_m = 0;
  logic [15:0]     snap_m = 16'h0;

  task automatic model_reset();
    led_m = 16'h0; sw_h0 = 4'h0; sw_h1 = 4'h0;
    en_m = 1'b0; ticks_m = 0; snap_m = 16'h0;
  endtask

  task automatic model_read(input logic [14:0] a, output logic [15:0] v, output bit c);
    logic [31:0] cnt;
    int off;
    cnt = 32'(ticks_m / longint'(P));
    v = 16'h0;
    c = 1'b1;
    if (a < 15'h4000) begin
      if (ram_m.exists(int'(a))) v = ram_m[int'(a)];
      else c = 1'b0;
    end else if (a >= 15'h6000 && a <= 15'h6007) begin
      off = int'(a) - 'h6000;
      if (off == 0) v = {12'h0, sw_h0};
      else if (off == 1) v = led_m;
`ifdef DATA_MEM_TIMER_EN
      else if (off == 2) v = cnt[15:0];
      else if (off == 3) v = snap_m;
      else if (off == 4) v = {15'h0, en_m};
`endif
    end
  endtask

  task automatic cyc(input bit we, input logic [14:0] wa, input logic [15:0] wd,
                     input logic [14:0] ra, input bit dir, input logic [15:0] dexp);
    logic [15:0] v;
    bit          c;
    exp_t        e;
    logic [31:0] cnt;
    @(negedge clk);
    bus.write_m = we; bus.write_data_addr = wa; bus.out_m = wd; bus.read_data_addr = ra;
    SW = sw_drv;
    model_read(ra, v, c);
    if (dir) begin v = dexp; c = 1'b1; end
    cnt = 32'(ticks_m / longint'(P));
`ifdef DATA_MEM_TIMER_EN
    if (ra == 15'h6002) snap_m = cnt[31:16];
    if (we && wa == 15'h6004) begin
      if (wd[1]) ticks_m = 0;
      else if (en_m) ticks_m++;
      en_m = wd[0];
    end else if (en_m) begin
      ticks_m++;
    end
`endif
    if (we && wa < 15'h4000) ram_m[int'(wa)] = wd;
    if (we && wa == 15'h6001) led_m = wd;
    sw_h0 = sw_h1; sw_h1 = sw_drv;
    e.cyc = cyc_cnt; e.chk = c; e.dir = dir; e.ra = ra; e.in_exp = v; e.led_exp = led_m;
    sb.push_back(e);
  endtask

  task automatic rd(input logic [14:0] ra); cyc(1'b0, 15'h0, 16'h0, ra, 1'b0, 16'h0); endtask
  task automatic rdx(input logic [14:0] ra, input logic [15:0] x); cyc(1'b0, 15'h0, 16'h0, ra, 1'b1, x); endtask
  task automatic wr(input logic [14:0] wa, input logic [15:0] wd, input logic [14:0] ra);
    cyc(1'b1, wa, wd, ra, 1'b0, 16'h0);
  endtask
  task automatic wrx(input logic [14:0] wa, input logic [15:0] wd, input logic [14:0] ra, input logic [15:0] x);
    cyc(1'b1, wa, wd, ra, 1'b1, x);
  endtask

  task automatic drain();
    int t = 0;
    @(posedge clk);
    #1 bus.write_m = 1'b0;
    while (sb.size() != 0 && t < 8) begin @(negedge clk); t++; end
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d scoreboard entries never matched by DUT output, want 0", sb.size());
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "scoreboard stuck");
    end
  endtask

  task automatic do_reset();
    drain();
    #2 resetN = 1'b0;
    SW = 4'h0; sw_drv = 4'h0;
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  function automatic logic [14:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return 15'h0100 + 15'($urandom_range(0, 63));
      4, 5, 6, 7: return 15'h6000 + 15'($urandom_range(0, 7));
      8:          return 15'h4000 + 15'($urandom_range(0, 'h1FFF));
      default:    return 15'h6008 + 15'($urandom_range(0, 'h1FF7));
    endcase
  endfunction

  // Monitor: while in reset the outputs must already be zero; otherwise retire every entry whose edge has passed.
  always begin
    @(negedge clk or negedge resetN);
    #1;
    if (!resetN) begin
      n_cmp++;
      if (bus.in_m !== 16'h0) begin n_bad++; $display("FAIL reset_in_m: got %h want 0000", bus.in_m); end
      n_cmp++;
      if (led !== 16'h0) begin n_bad++; $display("FAIL reset_led: got %h want 0000", led); end
    end else begin
      while (sb.size() > 0 && sb[0].cyc < cyc_cnt) begin
        mon_e = sb.pop_front();
        if (mon_e.chk) begin
          n_cmp++;
          if (bus.in_m !== mon_e.in_exp) begin
            n_bad++;
            $display("FAIL %s_read @%h (cyc %0d): in_m got %h want %h",
                     mon_e.dir ? "dir" : "rnd", mon_e.ra, mon_e.cyc, bus.in_m, mon_e.in_exp);
          end
        end
        n_cmp++;
        if (led !== mon_e.led_exp) begin
          n_bad++;
          $display("FAIL led (cyc %0d): got %h want %h", mon_e.cyc, led, mon_e.led_exp);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.write_m = 1'b0; bus.write_data_addr = 15'h0; bus.out_m = 16'h0; bus.read_data_addr = 15'h0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;

    // RAM round trip, unmapped read, read-first collision.
    wrx(15'h0010, 16'h1234, 15'h4000, 16'h0000);
    rdx(15'h0010, 16'h1234);
    wr (15'h0020, 16'hAAAA, 15'h4001);
    wrx(15'h0020, 16'h5555, 15'h0020, 16'hAAAA);
    rdx(15'h0020, 16'h5555);

    // LED, switches, dropped writes to unmapped / read-only / reserved words.
    wr (15'h6001, 16'h00F0, 15'h0010);
    rdx(15'h6001, 16'h00F0);
    sw_drv = 4'b1010;
    rd (15'h0010);
    rd (15'h0010);
    rdx(15'h6000, 16'h000A);
    wr (15'h4005, 16'hBEEF, 15'h0010);
    rdx(15'h4005, 16'h0000);
    wr (15'h6000, 16'hFFFF, 15'h0010);
    rdx(15'h6000, 16'h000A);
    wr (15'h6006, 16'h1111, 15'h0010);
    rdx(15'h6006, 16'h0000);

`ifdef DATA_MEM_TIMER_EN
    // Enabled after edge c, so a read issued i cycles later sees count i-1.
    wr(15'h6004, 16'h0001, 15'h4000);
    for (int i = 1; i <= 'h10007; i++) begin
      if (i == 'hFFF1)        rdx(15'h6002, 16'hFFF0);
      else if (i == 'h10005)  rdx(15'h6003, 16'h0000);
      else if (i == 'h10006)  rdx(15'h6002, 16'h0005);
      else if (i == 'h10007)  rdx(15'h6003, 16'h0001);
      else                    rd (15'h0010);
    end
    wr (15'h6004, 16'h0003, 15'h4000);
    rdx(15'h6002, 16'h0000);
    rdx(15'h6002, 16'h0001);
    rdx(15'h6004, 16'h0001);
    wrx(15'h6004, 16'h0000, 15'h6002, 16'h0003);
    repeat (100) rd(15'h0010);
    rdx(15'h6002, 16'h0004);
    rdx(15'h6004, 16'h0000);
`else
    wr (15'h6004, 16'h0003, 15'h0010);
    rdx(15'h6004, 16'h0000);
    rdx(15'h6002, 16'h0000);
    rdx(15'h6003, 16'h0000);
`endif

    // Reset mid-run with timer enabled and LED lit; in_m is holding a nonzero LED read when reset hits.
    wr(15'h6004, 16'h0001, 15'h0010);
    wr(15'h6001, 16'hFFFF, 15'h0010);
    repeat (5) rd(15'h0010);
    rd(15'h6001);
    do_reset();
    rdx(15'h6002, 16'h0000);
    rdx(15'h0010, 16'h1234);
    rdx(15'h6001, 16'h0000);
    rdx(15'h6004, 16'h0000);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 64; i++) wr(15'h0100 + 15'(i), 16'($urandom), rand_addr());
    for (int i = 0; i < 1500; i++) begin
      if (i % 8 == 0) sw_drv = 4'($urandom);
      if ($urandom_range(0, 1) == 1) wr(rand_addr(), 16'($urandom), rand_addr());
      else rd(rand_addr());
    end

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_mem_io.md
Name: data_mem_io

Overview:
- Responder end of the CPU data-memory interface.
- Takes the CPU write port (write_m, write_data_addr, out_m) and read port (read_data_addr -> in_m).
- Serves a synchronous data RAM plus a small memory-mapped I/O page: switch input, LED output register and cycle timer.
- Sits beside the cpu core at top level and replaces a bare RAM macro.

Parameters:
- RAM_AW, 14, RAM address width; RAM covers 0x0000..(2^RAM_AW - 1).
- IO_BASE, 15'h6000, base address of the I/O page (8 words, IO_BASE..IO_BASE+7).
- TIMER_PRESCALE, 1, clk cycles per timer tick; legal range 1..65535.

Ports:
- clk  in  1  clock
- resetN  in  1  reset, asynchronous, active-low
- write_m  in  1  write strobe from CPU, single cycle
- write_data_addr  in  15  write address
- out_m  in  16  write data
- read_data_addr  in  15  read address, presented every cycle (no read strobe)
- in_m  out  16  read data, registered, valid 1 cycle after read_data_addr
- SW  in  4  asynchronous board switches
- led  out  16  LED output register

Behaviour:
- Reset: in_m=0, led=0, switch synchronizer=0, timer count=0, snapshot=0, timer ctrl=0 (disabled), prescaler=0. RAM contents are not reset.
- Decode (both ports): RAM if addr < 2^RAM_AW; IO if addr[14:3]==IO_BASE[14:3]; otherwise unmapped.
- Unmapped reads return 16'h0000. Unmapped writes are dropped.
- Read latency is exactly 1 cycle: in_m(t+1) = mem[read_data_addr(t)]. Reads happen every cycle and are unconditional.
- Read-first semantics: a write and a read to the same address in the same cycle return the OLD value. The CPU bypass depends on this; write-first is forbidden.
- Writes commit at the clk edge where write_m=1.
- I/O map (offset from IO_BASE):
  - +0 SW (RO): {12'b0, sw_sync}. Two-flop synchronizer, so 2-3 cycles latency from a pin change.
  - +1 LED (RW): write sets led; read returns the current register value.
  - +2 TIMER_LO (RO): returns count[15:0]. The same read latches count[31:16] into the snapshot.
  - +3 TIMER_HI (RO): returns the snapshot, not the live high half.
  - +4 TIMER_CTRL (RW): bit0 = enable. bit1 = clear, write-only and self-clearing: on write, count=0 and prescaler=0 next cycle. Reads return {15'b0, enable}.
  - +5..+7: reserved; read 0, writes ignored.
- Writes to RO registers are ignored.
- Timer:
  - When enabled, the prescaler counts 0..TIMER_PRESCALE-1. On wrap, the 32-bit count increments.
  - count wraps from 32'hFFFFFFFF to 0 with no flag.
  - Clear and an increment in the same cycle: clear wins.
  - Disabling freezes both count and prescaler.
- Simultaneous TIMER_LO read and clear write in the same cycle: the read returns the pre-clear value and the snapshot latches the pre-clear high half.
- A read of +2 in consecutive cycles re-latches the snapshot each time.
- Reset asserted mid-operation: all registers clear asynchronously and in_m drops to 0 immediately. A write in flight during reset may or may not reach RAM; it is undefined and the bench does not check it.

Optional Feature:
- DATA_MEM_TIMER_EN defined: timer, snapshot and TIMER_CTRL implemented as above.
- DATA_MEM_TIMER_EN undefined: offsets +2..+4 behave as reserved (read 0, writes ignored) and no timer flops are built. SW and LED are unchanged.

Test Plan:
- RAM round trip: write 0x1234 @0x0010. Next cycle read_data_addr=0x0010 -> in_m=0x1234 one cycle later. Read @0x4000 -> 0x0000.
- Read-first collision: mem[0x20]=0xAAAA. Same cycle write 0x5555 @0x20 and read @0x20 -> in_m=0xAAAA. Read @0x20 next cycle -> 0x5555.
- LED / SW: write 0x00F0 @0x6001 -> led=0x00F0 next edge and read @0x6001 returns 0x00F0. Set SW=4'b1010 -> read @0x6000 returns 0x000A within 3 cycles.
- Timer (TIMER_EN, PRESCALE=1): write 1 @0x6004. After 0x10005 cycles, read @0x6002 then @0x6003 -> LO/HI consistent with count 0x00010005±read skew, and HI equals the snapshot even after the low half wraps.
- Timer clear: while running, write 0x0003 @0x6004 -> count=0 next cycle and still enabled. Write 0 -> count frozen across 100 cycles.
- Reset mid-run: timer enabled, led=0xFFFF, assert resetN=0 -> led=0, in_m=0 immediately. After release, a TIMER_LO read returns 0 and mem[0x0010] still returns its pre-reset value.
